// File: rtl/fsm_cu_pkg.sv
// Shared definitions for the calculator control unit: state codes,
// write-data mux select codes and register-file addresses.
package fsm_cu_pkg;

    // State codes are fixed because cs is exported to the datapath and to debug.
    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;

    // Write-data mux (s1) select codes.
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_IDLE = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_A    = 2'b11;

    // Register-file addresses.
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    // ALU function code used when R3 is read back for the output port.
    localparam logic [1:0] C_READOUT = 2'b10;

    // Maps the op field onto the compute state that performs that operation.
    function automatic state_t op_state(input logic [1:0] op);
        state_t s;
        case (op)
            2'b00:   s = S4;
            2'b01:   s = S5;
            2'b10:   s = S6;
            default: s = S7;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fsm_cu_decode.sv
// Pure combinational decode of the current state into datapath controls.
// Anything outside S0..S8 decodes to the idle (S0) values.
module fsm_cu_decode
    import fsm_cu_pkg::*;
(
    input  logic [3:0] cs,
    output logic       we,
    output logic       rea,
    output logic       reb,
    output logic       s2,
    output logic       done,
    output logic [1:0] s1,
    output logic [1:0] wa,
    output logic [1:0] raa,
    output logic [1:0] rab,
    output logic [1:0] c
);

    // Moore output table; idle values first so unused codes fall back to S0.
    always_comb begin
        s1   = SEL_IDLE;
        wa   = R0;
        we   = 1'b0;
        raa  = R0;
        rea  = 1'b0;
        rab  = R0;
        reb  = 1'b0;
        c    = 2'b00;
        s2   = 1'b0;
        done = 1'b0;
        case (cs)
            S1: begin
                s1 = SEL_A;
                wa = R1;
                we = 1'b1;
            end
            S2: begin
                s1 = SEL_B;
                wa = R2;
                we = 1'b1;
            end
            S4, S5, S6, S7: begin
                s1  = SEL_ALU;
                wa  = R3;
                we  = 1'b1;
                raa = R1;
                rea = 1'b1;
                rab = R2;
                reb = 1'b1;
                // S4..S7 are 4+op, so the low state bits are the ALU function.
                c   = cs[1:0];
            end
            S8: begin
                raa  = R3;
                rea  = 1'b1;
                rab  = R3;
                reb  = 1'b1;
                c    = C_READOUT;
                done = 1'b1;
            end
            default: begin
                s1 = SEL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fsm_cu.sv
// Calculator control unit: loads A into R1, B into R2, computes
// R3 = R1 op R2, then presents R3 on both read ports with done raised.
module fsm_cu
    import fsm_cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] op,
    output logic       we,
    output logic       rea,
    output logic       reb,
    output logic       s2,
    output logic       done,
    output logic [3:0] cs,
    output logic [1:0] s1,
    output logic [1:0] wa,
    output logic [1:0] raa,
    output logic [1:0] rab,
    output logic [1:0] c
);

    state_t state;
    state_t next_state;

    // State register; synchronous reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; go only matters in S0 and op only in S3.
    always_comb begin
        next_state = S0;
        case (state)
            S0:                 next_state = go ? S1 : S0;
            S1:                 next_state = S2;
            S2:                 next_state = S3;
            S3:                 next_state = op_state(op);
            S4, S5, S6, S7:     next_state = S8;
            S8:                 next_state = S0;
            default:            next_state = S0;
        endcase
    end

    assign cs = state;

    fsm_cu_decode u_decode (
        .cs   (cs),
        .we   (we),
        .rea  (rea),
        .reb  (reb),
        .s2   (s2),
        .done (done),
        .s1   (s1),
        .wa   (wa),
        .raa  (raa),
        .rab  (rab),
        .c    (c)
    );

endmodule

// File: tb/tb_fsm_cu.sv
// Self-checking bench for fsm_cu: a state-rule model checked every cycle
// plus hand-computed literal expectations for the directed scenarios.
module tb_fsm_cu;

    logic       clk;
    logic       rst;
    logic       go;
    logic [1:0] op;
    logic       we;
    logic       rea;
    logic       reb;
    logic       s2;
    logic       done;
    logic [3:0] cs;
    logic [1:0] s1;
    logic [1:0] wa;
    logic [1:0] raa;
    logic [1:0] rab;
    logic [1:0] c;

    int errors = 0;
    int checks = 0;

    int m_state = 0;
    bit m_valid = 1'b0;

    fsm_cu dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .op   (op),
        .we   (we),
        .rea  (rea),
        .reb  (reb),
        .s2   (s2),
        .done (done),
        .cs   (cs),
        .s1   (s1),
        .wa   (wa),
        .raa  (raa),
        .rab  (rab),
        .c    (c)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control bundle {s1,wa,we,raa,rea,rab,reb,c,s2,done} for a state.
    function automatic logic [14:0] model_ctrl(input int s);
        logic [1:0] e_s1, e_wa, e_raa, e_rab, e_c;
        logic       e_we, e_rea, e_reb, e_s2, e_done;
        e_s1 = 2'b01; e_wa = 2'b00; e_we = 1'b0;
        e_raa = 2'b00; e_rea = 1'b0; e_rab = 2'b00; e_reb = 1'b0;
        e_c = 2'b00; e_s2 = 1'b0; e_done = 1'b0;
        if (s == 1) begin
            e_s1 = 2'b11; e_wa = 2'b01; e_we = 1'b1;
        end else if (s == 2) begin
            e_s1 = 2'b10; e_wa = 2'b10; e_we = 1'b1;
        end else if (s >= 4 && s <= 7) begin
            e_s1 = 2'b00; e_wa = 2'b11; e_we = 1'b1;
            e_raa = 2'b01; e_rea = 1'b1; e_rab = 2'b10; e_reb = 1'b1;
            e_c = 2'(s - 4);
        end else if (s == 8) begin
            e_raa = 2'b11; e_rea = 1'b1; e_rab = 2'b11; e_reb = 1'b1;
            e_c = 2'b10; e_done = 1'b1;
        end
        return {e_s1, e_wa, e_we, e_raa, e_rea, e_rab, e_reb, e_c, e_s2, e_done};
    endfunction

    // Next state from the sequencing rules: go, load A, load B, decode, compute, done.
    function automatic int model_next(input int s, input logic g, input logic [1:0] o);
        if (s == 0)                return g ? 1 : 0;
        else if (s == 1)           return 2;
        else if (s == 2)           return 3;
        else if (s == 3)           return 4 + int'(o);
        else if (s >= 4 && s <= 7) return 8;
        else                       return 0;
    endfunction

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_state <= model_next(m_state, go, op);
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({cs, s1, wa, we, raa, rea, rab, reb, c, s2, done} !==
                {4'(m_state), model_ctrl(m_state)}) begin
                errors++;
                $display("[TB] FAIL model_cycle: got cs=%0d ctrl=%b, expected cs=%0d ctrl=%b",
                         cs, {s1, wa, we, raa, rea, rab, reb, c, s2, done},
                         m_state, model_ctrl(m_state));
            end
        end
    end

    // Drive inputs just after an edge, then wait through the next edge.
    task automatic applyStimulus(input logic r, input logic g, input logic [1:0] o);
        rst = r;
        go  = g;
        op  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    logic [1:0] op_list [3];

    initial begin
        op_list[0] = 2'b00;
        op_list[1] = 2'b01;
        op_list[2] = 2'b11;

        // Reset for one edge.
        applyStimulus(1'b1, 1'b0, 2'b00);
        checkOutput("reset_cs", 32'(cs), 32'd0);
        checkOutput("reset_s1", 32'(s1), 32'd1);
        checkOutput("reset_others", 32'({wa, we, raa, rea, rab, reb, c, s2, done}), 32'd0);

        // Idle with go low.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11);
            checkOutput("idle_cs", 32'(cs), 32'd0);
        end

        // Full operation with op=10; go/op wiggled where they must be ignored.
        applyStimulus(1'b0, 1'b1, 2'b01);
        checkOutput("s1_cs", 32'(cs), 32'd1);
        checkOutput("s1_ctrl", 32'({s1, wa, we}), 32'b11_01_1);
        applyStimulus(1'b0, 1'b1, 2'b01);
        checkOutput("s2_cs", 32'(cs), 32'd2);
        checkOutput("s2_ctrl", 32'({s1, wa, we}), 32'b10_10_1);
        applyStimulus(1'b0, 1'b1, 2'b01);
        checkOutput("s3_cs", 32'(cs), 32'd3);
        applyStimulus(1'b0, 1'b0, 2'b10);
        checkOutput("s6_cs", 32'(cs), 32'd6);
        checkOutput("s6_c", 32'(c), 32'b10);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("s8_cs", 32'(cs), 32'd8);
        checkOutput("s8_done", 32'(done), 32'd1);
        checkOutput("s8_ctrl", 32'({raa, rab, rea, reb, c, we, s2}), 32'b11_11_1_1_10_0_0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("back_cs", 32'(cs), 32'd0);
        checkOutput("back_done", 32'(done), 32'd0);

        // Remaining op codes select S4, S5, S7.
        foreach (op_list[k]) begin
            applyStimulus(1'b0, 1'b1, ~op_list[k]);
            applyStimulus(1'b0, 1'b0, ~op_list[k]);
            applyStimulus(1'b0, 1'b0, ~op_list[k]);
            applyStimulus(1'b0, 1'b0, op_list[k]);
            checkOutput("op_cs", 32'(cs), 32'd4 + 32'(op_list[k]));
            checkOutput("op_ctrl", 32'({wa, raa, rab, we, rea, reb}), 32'b11_01_10_1_1_1);
            checkOutput("op_c", 32'(c), 32'(op_list[k]));
            applyStimulus(1'b0, 1'b0, 2'b00);
            checkOutput("op_done", 32'(done), 32'd1);
            applyStimulus(1'b0, 1'b0, 2'b00);
            checkOutput("op_idle", 32'(cs), 32'd0);
        end

        // Reset while in S2.
        applyStimulus(1'b0, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("pre_rst_s2", 32'(cs), 32'd2);
        applyStimulus(1'b1, 1'b0, 2'b00);
        checkOutput("rst_from_s2", 32'(cs), 32'd0);
        checkOutput("rst_from_s2_we", 32'(we), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("hold_after_s2_rst", 32'(cs), 32'd0);

        // Reset while in S5.
        applyStimulus(1'b0, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b01);
        checkOutput("pre_rst_s5", 32'(cs), 32'd5);
        applyStimulus(1'b1, 1'b1, 2'b01);
        checkOutput("rst_from_s5", 32'(cs), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("hold_after_s5_rst", 32'(cs), 32'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
